// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
//   Multi-cycle control unit for an IF/ID/EX/MEM/WB datapath. Owns the stage
//   register, decodes the opcode into datapath enables, waits on data memory
//   with a timeout, resolves branches from ALU flags, traps illegal opcodes
//   and counts retired instructions.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IF    | fetch: write IR, PC <= PC+1
//   ID    | decode: J completes here, illegal opcodes trap here
//   EX    | ALU op / branch resolution / SP arithmetic for stack ops
//   MEM   | data memory access, held while mem_ready=0, timeout abort
//   WB    | register write-back
//
// Ports
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_opcode                  opcode from IR (stable from ID onward)
//   i_zero/carry/neg_flag     ALU flags, valid in EX (carry unused)
//   i_mem_ready               data memory completes the access this cycle
//   o_state                   IF=0 ID=1 EX=2 MEM=3 WB=4
//   o_pc_src, o_pc_we, o_ir_we, o_ext_src, o_reg_des, o_alu_src, o_j_src,
//   o_wb_data, o_reg_w1, o_reg_w2, o_mem_read, o_mem_write, o_sp_sel
//                             datapath controls, combinational on state/opcode
//   o_instr_done              pulse on the last state of each instruction
//   o_illegal_op, o_mem_err   sticky error flags, cleared by reset only
//   o_retired                 count of o_instr_done pulses (wraps)

module multicycle_ctrl_fsm #(
    parameter int OPCODE_W    = 6,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4,
    parameter int CNT_W       = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_zero_flag,
    input  logic                i_carry_flag,
    input  logic                i_neg_flag,
    input  logic                i_mem_ready,
    output logic [2:0]          o_state,
    output logic [1:0]          o_pc_src,
    output logic                o_pc_we,
    output logic                o_ir_we,
    output logic                o_ext_src,
    output logic                o_reg_des,
    output logic                o_alu_src,
    output logic                o_j_src,
    output logic [1:0]          o_wb_data,
    output logic                o_reg_w1,
    output logic                o_reg_w2,
    output logic                o_mem_read,
    output logic                o_mem_write,
    output logic                o_sp_sel,
    output logic                o_instr_done,
    output logic                o_illegal_op,
    output logic                o_mem_err,
    output logic [CNT_W-1:0]    o_retired
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_LWPOI = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_BGT   = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_BLT   = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(10);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(11);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(12);
    localparam logic [OPCODE_W-1:0] OP_CALL  = OPCODE_W'(13);
    localparam logic [OPCODE_W-1:0] OP_RET   = OPCODE_W'(14);
    localparam logic [OPCODE_W-1:0] OP_PUSH  = OPCODE_W'(15);
    localparam logic [OPCODE_W-1:0] OP_POP   = OPCODE_W'(16);

    // Last wait-count value before the cycle that would reach MEM_TIMEOUT.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TO_W-1:0]  r_wait_cnt;
    logic             r_illegal_op;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_retired;

    logic w_is_rtype, w_is_imm, w_is_branch, w_is_stack, w_is_illegal;
    logic w_is_mem_rd, w_is_mem_wr, w_is_load, w_br_taken;
    logic w_set_ill, w_set_merr, w_cnt_inc, w_cnt_clr;

    // Carry is reserved for future branch types.
    logic w_unused_carry;
    assign w_unused_carry = i_carry_flag;

    assign w_is_rtype   = (i_opcode < OP_ADDI);
    assign w_is_imm     = (i_opcode >= OP_ADDI) && (i_opcode <= OP_SW);
    assign w_is_branch  = (i_opcode >= OP_BGT)  && (i_opcode <= OP_BNE);
    assign w_is_stack   = (i_opcode >= OP_CALL) && (i_opcode <= OP_POP);
    assign w_is_illegal = (i_opcode > OP_POP);
    assign w_is_load    = (i_opcode == OP_LW) || (i_opcode == OP_LWPOI) || (i_opcode == OP_POP);
    assign w_is_mem_rd  = w_is_load || (i_opcode == OP_RET);
    assign w_is_mem_wr  = (i_opcode == OP_SW) || (i_opcode == OP_CALL) || (i_opcode == OP_PUSH);

    always_comb begin
        w_br_taken = 1'b0;
        case (i_opcode)
            OP_BGT:  w_br_taken = !i_zero_flag && !i_neg_flag;
            OP_BLT:  w_br_taken = i_neg_flag;
            OP_BEQ:  w_br_taken = i_zero_flag;
            OP_BNE:  w_br_taken = !i_zero_flag;
            default: w_br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IF;
            r_wait_cnt   <= '0;
            r_illegal_op <= 1'b0;
            r_mem_err    <= 1'b0;
            r_retired    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cnt_clr) begin
                r_wait_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_wait_cnt <= r_wait_cnt + TO_W'(1);
            end
            if (w_set_ill) begin
                r_illegal_op <= 1'b1;
            end
            if (w_set_merr) begin
                r_mem_err <= 1'b1;
            end
            if (o_instr_done) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_pc_src     = 2'b00;
        o_pc_we      = 1'b0;
        o_ir_we      = 1'b0;
        o_ext_src    = 1'b0;
        o_reg_des    = 1'b0;
        o_alu_src    = 1'b0;
        o_j_src      = 1'b0;
        o_wb_data    = 2'b00;
        o_reg_w1     = 1'b0;
        o_reg_w2     = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_sp_sel     = 1'b0;
        o_instr_done = 1'b0;
        w_set_ill    = 1'b0;
        w_set_merr   = 1'b0;
        w_cnt_inc    = 1'b0;
        w_cnt_clr    = 1'b0;

        case (r_state)
            S_IF: begin
                o_ir_we     = 1'b1;
                o_pc_we     = 1'b1;
                w_state_nxt = S_ID;
            end

            S_ID: begin
                if (i_opcode == OP_J) begin
                    o_pc_we      = 1'b1;
                    o_pc_src     = 2'b01;
                    o_j_src      = 1'b1;
                    o_instr_done = 1'b1;
                    w_state_nxt  = S_IF;
                end else if (w_is_illegal) begin
                    w_set_ill    = 1'b1;
                    o_instr_done = 1'b1;
                    w_state_nxt  = S_IF;
                end else begin
                    w_state_nxt  = S_EX;
                end
            end

            S_EX: begin
                o_alu_src = w_is_imm;
                o_ext_src = w_is_imm;
                o_sp_sel  = w_is_stack;
                if (w_is_branch) begin
                    o_instr_done = 1'b1;
                    w_state_nxt  = S_IF;
                    if (w_br_taken) begin
                        o_pc_we  = 1'b1;
                        o_pc_src = 2'b10;
                    end
                end else if (w_is_rtype || i_opcode <= OPCODE_W'(4)) begin
                    w_state_nxt = S_WB;
                end else if (w_is_mem_rd || w_is_mem_wr) begin
                    w_state_nxt = S_MEM;
                end else begin
                    // J and illegal opcodes never reach EX; recover to fetch.
                    w_state_nxt = S_IF;
                end
            end

            S_MEM: begin
                o_mem_read  = w_is_mem_rd;
                o_mem_write = w_is_mem_wr;
                o_sp_sel    = w_is_stack;
                // Completion wins over timeout on the final wait cycle.
                if (i_mem_ready) begin
                    w_cnt_clr = 1'b1;
                    if (w_is_load) begin
                        w_state_nxt = S_WB;
                    end else begin
                        o_instr_done = 1'b1;
                        w_state_nxt  = S_IF;
                        if (i_opcode == OP_CALL) begin
                            o_reg_w2 = 1'b1;
                            o_pc_we  = 1'b1;
                            o_pc_src = 2'b01;
                        end else if (i_opcode == OP_RET) begin
                            o_reg_w2 = 1'b1;
                            o_pc_we  = 1'b1;
                            o_pc_src = 2'b11;
                        end else begin
                            o_reg_w2 = (i_opcode == OP_PUSH);
                        end
                    end
                end else if (r_wait_cnt == TO_LAST) begin
                    w_set_merr   = 1'b1;
                    w_cnt_clr    = 1'b1;
                    o_instr_done = 1'b1;
                    w_state_nxt  = S_IF;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end

            S_WB: begin
                o_reg_w1     = 1'b1;
                o_reg_des    = !w_is_rtype;
                o_wb_data    = w_is_load ? 2'b01 : 2'b00;
                o_reg_w2     = (i_opcode == OP_LWPOI) || (i_opcode == OP_POP);
                o_instr_done = 1'b1;
                w_state_nxt  = S_IF;
            end

            default: begin
                w_state_nxt = S_IF;
            end
        endcase
    end

    assign o_state      = r_state;
    assign o_illegal_op = r_illegal_op;
    assign o_mem_err    = r_mem_err;
    assign o_retired    = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero_flag, carry_flag, neg_flag, mem_ready;
    logic [2:0] state;
    logic [1:0] pc_src, wb_data;
    logic       pc_we, ir_we, ext_src, reg_des, alu_src, j_src;
    logic       reg_w1, reg_w2, mem_read, mem_write, sp_sel, instr_done;
    logic       illegal_op, mem_err;
    logic [15:0] retired;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(
        .OPCODE_W(6), .MEM_TIMEOUT(15), .TO_W(4), .CNT_W(16)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode),
        .i_zero_flag(zero_flag), .i_carry_flag(carry_flag), .i_neg_flag(neg_flag),
        .i_mem_ready(mem_ready),
        .o_state(state), .o_pc_src(pc_src), .o_pc_we(pc_we), .o_ir_we(ir_we),
        .o_ext_src(ext_src), .o_reg_des(reg_des), .o_alu_src(alu_src), .o_j_src(j_src),
        .o_wb_data(wb_data), .o_reg_w1(reg_w1), .o_reg_w2(reg_w2),
        .o_mem_read(mem_read), .o_mem_write(mem_write), .o_sp_sel(sp_sel),
        .o_instr_done(instr_done), .o_illegal_op(illegal_op), .o_mem_err(mem_err),
        .o_retired(retired)
    );

    // Control word: {pc_src, pc_we, ir_we, ext_src, reg_des, alu_src, j_src,
    //                wb_data, reg_w1, reg_w2, mem_read, mem_write, sp_sel, done}
    localparam logic [15:0] PS_J = 16'h4000, PS_B = 16'h8000, PS_M = 16'hC000;
    localparam logic [15:0] PCWE = 16'h2000, IRWE = 16'h1000, EXT  = 16'h0800;
    localparam logic [15:0] RDES = 16'h0400, ALUS = 16'h0200, JS   = 16'h0100;
    localparam logic [15:0] WBM  = 16'h0040, RW1  = 16'h0020, RW2  = 16'h0010;
    localparam logic [15:0] MRD  = 16'h0008, MWR  = 16'h0004, SPS  = 16'h0002;
    localparam logic [15:0] DONE = 16'h0001;
    localparam logic [15:0] FETCH = PCWE | IRWE;

    typedef struct {
        logic        rst_n;
        logic [5:0]  op;
        logic        z, c, n, mr;
        logic [2:0]  st;
        logic [15:0] ctl;
        logic        ill, merr;
        logic [15:0] ret;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    int   n_checks = 0;
    int   n_errors = 0;
    logic g_ill = 1'b0, g_merr = 1'b0;
    logic [15:0] g_ret = 16'd0;

    function automatic void add(logic rst, int op, logic z, logic c, logic n,
                                logic mr, int st, logic [15:0] ctl);
        vec_t v;
        v.rst_n = rst; v.op = 6'(op); v.z = z; v.c = c; v.n = n; v.mr = mr;
        v.st = 3'(st); v.ctl = ctl; v.ill = g_ill; v.merr = g_merr; v.ret = g_ret;
        vecs.push_back(v);
        if (!rst) begin
            g_ret = 16'd0; g_ill = 1'b0; g_merr = 1'b0;
        end else if (ctl[0]) begin
            g_ret = g_ret + 16'd1;
        end
    endfunction

    // IF and a plain ID cycle for an opcode that continues to EX.
    function automatic void pre(int op);
        add(1, op, 0, 0, 0, 0, 0, FETCH);
        add(1, op, 0, 0, 0, 0, 1, 16'h0000);
    endfunction

    function automatic void branch(int op, logic z, logic c, logic n, logic taken);
        add(1, op, z, c, n, 0, 0, FETCH);
        add(1, op, z, c, n, 0, 1, 16'h0000);
        add(1, op, z, c, n, 0, 2, taken ? (PS_B | PCWE | DONE) : DONE);
    endfunction

    function automatic logic [15:0] dut_ctl();
        return {pc_src, pc_we, ir_we, ext_src, reg_des, alu_src, j_src,
                wb_data, reg_w1, reg_w2, mem_read, mem_write, sp_sel, instr_done};
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        // ADD then LW, memory ready at once
        pre(0);
        add(1, 0, 0, 0, 0, 0, 2, 16'h0000);
        add(1, 0, 0, 0, 0, 0, 4, RW1 | DONE);
        pre(5);
        add(1, 5, 0, 0, 0, 0, 2, ALUS | EXT);
        add(1, 5, 0, 0, 0, 1, 3, MRD);
        add(1, 5, 0, 0, 0, 0, 4, RW1 | RDES | WBM | DONE);
        // branches, carry toggled to show it is ignored
        branch(10, 1, 0, 0, 1);
        branch(11, 1, 0, 0, 0);
        branch(8,  0, 1, 0, 1);
        branch(8,  1, 0, 0, 0);
        branch(8,  0, 0, 1, 0);
        branch(9,  0, 1, 1, 1);
        branch(9,  1, 1, 0, 0);
        branch(11, 0, 0, 1, 1);
        // SW with three wait cycles
        pre(7);
        add(1, 7, 0, 0, 0, 0, 2, ALUS | EXT);
        for (int i = 0; i < 3; i++) add(1, 7, 0, 0, 0, 0, 3, MWR);
        add(1, 7, 0, 0, 0, 1, 3, MWR | DONE);
        // J
        add(1, 12, 0, 0, 0, 0, 0, FETCH);
        add(1, 12, 0, 0, 0, 0, 1, PS_J | PCWE | JS | DONE);
        // CALL, RET, PUSH, POP
        pre(13);
        add(1, 13, 0, 0, 0, 0, 2, SPS);
        add(1, 13, 0, 0, 0, 1, 3, MWR | SPS | RW2 | PCWE | PS_J | DONE);
        pre(14);
        add(1, 14, 0, 0, 0, 0, 2, SPS);
        add(1, 14, 0, 0, 0, 1, 3, MRD | SPS | RW2 | PCWE | PS_M | DONE);
        pre(15);
        add(1, 15, 0, 0, 0, 0, 2, SPS);
        add(1, 15, 0, 0, 0, 1, 3, MWR | SPS | RW2 | DONE);
        pre(16);
        add(1, 16, 0, 0, 0, 0, 2, SPS);
        add(1, 16, 0, 0, 0, 1, 3, MRD | SPS);
        add(1, 16, 0, 0, 0, 0, 4, RW1 | RDES | WBM | RW2 | DONE);
        // LWPOI, ADDI, R-type 2
        pre(6);
        add(1, 6, 0, 0, 0, 0, 2, ALUS | EXT);
        add(1, 6, 0, 0, 0, 1, 3, MRD);
        add(1, 6, 0, 0, 0, 0, 4, RW1 | RDES | WBM | RW2 | DONE);
        pre(3);
        add(1, 3, 0, 0, 0, 0, 2, ALUS | EXT);
        add(1, 3, 0, 0, 0, 0, 4, RW1 | RDES | DONE);
        pre(2);
        add(1, 2, 0, 0, 0, 0, 2, 16'h0000);
        add(1, 2, 0, 0, 0, 0, 4, RW1 | DONE);
        // LW: ready arrives on the 15th MEM cycle -> completion, not timeout
        pre(5);
        add(1, 5, 0, 0, 0, 0, 2, ALUS | EXT);
        for (int i = 0; i < 14; i++) add(1, 5, 0, 0, 0, 0, 3, MRD);
        add(1, 5, 0, 0, 0, 1, 3, MRD);
        add(1, 5, 0, 0, 0, 0, 4, RW1 | RDES | WBM | DONE);
        // LW: memory never ready -> abort after 15 MEM cycles
        pre(5);
        add(1, 5, 0, 0, 0, 0, 2, ALUS | EXT);
        for (int i = 0; i < 14; i++) add(1, 5, 0, 0, 0, 0, 3, MRD);
        add(1, 5, 0, 0, 0, 0, 3, MRD | DONE);
        g_merr = 1'b1;
        // illegal opcodes: first code past the map, then 40
        add(1, 17, 0, 0, 0, 0, 0, FETCH);
        add(1, 17, 0, 0, 0, 0, 1, DONE);
        g_ill = 1'b1;
        add(1, 40, 0, 0, 0, 0, 0, FETCH);
        add(1, 40, 0, 0, 0, 0, 1, DONE);
        // sticky flags persist across a normal instruction
        pre(0);
        add(1, 0, 0, 0, 0, 0, 2, 16'h0000);
        add(1, 0, 0, 0, 0, 0, 4, RW1 | DONE);
        // reset for two cycles inside an LW wait
        pre(5);
        add(1, 5, 0, 0, 0, 0, 2, ALUS | EXT);
        add(1, 5, 0, 0, 0, 0, 3, MRD);
        add(0, 5, 0, 0, 0, 0, 3, MRD);
        add(0, 5, 0, 0, 0, 0, 0, FETCH);
        // wait counter must restart from zero: 14 waits then ready completes
        pre(5);
        add(1, 5, 0, 0, 0, 0, 2, ALUS | EXT);
        for (int i = 0; i < 14; i++) add(1, 5, 0, 0, 0, 0, 3, MRD);
        add(1, 5, 0, 0, 0, 1, 3, MRD);
        add(1, 5, 0, 0, 0, 0, 4, RW1 | RDES | WBM | DONE);
        add(1, 12, 0, 0, 0, 0, 0, FETCH);

        rst_n = 1'b0; opcode = '0; zero_flag = 0; carry_flag = 0; neg_flag = 0; mem_ready = 0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t e;
            @(negedge clk);
            rst_n      = vecs[i].rst_n;
            opcode     = vecs[i].op;
            zero_flag  = vecs[i].z;
            carry_flag = vecs[i].c;
            neg_flag   = vecs[i].n;
            mem_ready  = vecs[i].mr;
            sb.push_back(vecs[i]);
            #1;
            e = sb.pop_front();
            chk("state",   i, 32'(state),      32'(e.st));
            chk("ctl",     i, 32'(dut_ctl()),  32'(e.ctl));
            chk("illegal", i, 32'(illegal_op), 32'(e.ill));
            chk("mem_err", i, 32'(mem_err),    32'(e.merr));
            chk("retired", i, 32'(retired),    32'(e.ret));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Next-generation multi-cycle control unit for the IF/ID/EX/MEM/WB datapath.
- Owns its state register, so the datapath no longer drives the stage.
- Adds memory wait states with a timeout, stack instructions (CALL/RET/PUSH/POP), flag-based branch resolution, illegal-opcode trapping and a retired-instruction counter.
- Sits between the instruction register/flag register and all datapath enables.

Parameters:
OPCODE_W, 6, opcode width; codes above 16 are illegal.
MEM_TIMEOUT, 15, max consecutive cycles in MEM with mem_ready low before abort (≥1).
TO_W, 4, width of the wait counter; must hold MEM_TIMEOUT.
CNT_W, 16, width of retired-instruction counter.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset.
opcode  in  OPCODE_W  from IR; stable from ID until the instruction's last state.
zero_flag, carry_flag, neg_flag  in  1 each  ALU flags, valid in EX.
mem_ready  in  1  data memory completes the access this cycle.
state  out  3  current stage: IF=0, ID=1, EX=2, MEM=3, WB=4.
pc_src  out  2  00 PC+1, 01 jump/call target, 10 branch target, 11 memory data (RET).
pc_we, ir_we  out  1  PC write and IR write.
ext_src, reg_des, alu_src, j_src  out  1  datapath selects.
wb_data  out  2  00 ALU, 01 memory, 10 PC+1.
reg_w1, reg_w2  out  1  write Rd; write base/SP register.
mem_read, mem_write  out  1  data memory strobes.
sp_sel  out  1  address/base = SP.
instr_done  out  1  one-cycle pulse on the last state of each instruction.
illegal_op, mem_err  out  1  sticky error flags, cleared only by reset.
retired  out  CNT_W  count of instr_done pulses; wraps to 0.

Behaviour:
- Reset (rst_n low at an edge, from any state, including during a MEM wait):
  - state=IF; wait counter, retired, illegal_op and mem_err = 0.
- Output decode:
  - All control outputs are combinational on the registered state and the opcode.
  - Any output not listed for a state is 0. Reset values follow from state=IF.
- Opcode map:
  - 0–2 R-type, 3 ADDI, 4 ANDI, 5 LW, 6 LWPOI, 7 SW.
  - 8 BGT, 9 BLT, 10 BEQ, 11 BNE, 12 J, 13 CALL, 14 RET, 15 PUSH, 16 POP.
- IF: ir_we=1, pc_we=1, pc_src=00. Next state is ID.
- ID:
  - J: pc_we=1, pc_src=01, j_src=1, instr_done → IF.
  - Illegal opcode: set illegal_op, instr_done → IF.
  - Otherwise → EX.
- EX: alu_src=1 and ext_src=1 for opcodes 3–7.
  - Branch taken conditions:
    - BGT: !zero_flag && !neg_flag.
    - BLT: neg_flag.
    - BEQ: zero_flag.
    - BNE: !zero_flag.
  - Taken branch: pc_we=1, pc_src=10. Every branch asserts instr_done → IF. carry_flag is reserved and ignored.
  - Opcodes 0–4 → WB. Opcodes 5–7 and 13–16 → MEM.
  - sp_sel=1 for opcodes 13–16 (SP arithmetic in ALU).
- MEM:
  - mem_read=1 for 5, 6, 14, 16. mem_write=1 for 7, 13, 15. sp_sel=1 for 13–16.
  - Strobes are held every cycle while mem_ready=0; the wait counter increments each such cycle.
  - On mem_ready=1: counter clears. Then:
    - 5, 6, 16 → WB.
    - CALL: reg_w2=1 (SP update), pc_we=1, pc_src=01, instr_done → IF.
    - RET: reg_w2=1, pc_we=1, pc_src=11, instr_done → IF.
    - SW and PUSH: reg_w2 asserted for PUSH only, instr_done → IF.
  - Timeout: counter reaching MEM_TIMEOUT with mem_ready still 0:
    - set mem_err, clear counter, instr_done, → IF.
    - No register or PC write occurs.
  - mem_ready=1 on the same cycle the counter hits MEM_TIMEOUT counts as completion, not timeout.
- WB: reg_w1=1, instr_done → IF.
  - reg_des=0 for R-type, 1 otherwise.
  - wb_data=01 for 5, 6, 16; else 00.
  - reg_w2=1 additionally for LWPOI (base post-increment) and POP (SP).
- Latencies with mem_ready=1 on first MEM cycle:
  - J 2 cycles; branches 3; R/I-type 4; SW/PUSH/CALL/RET 4; LW/LWPOI/POP 5.
  - Each MEM wait cycle adds 1.
- retired increments on every instr_done, including trapped and aborted instructions.

Test Plan:
- rst_n low 2 cycles in MEM of LW with mem_ready=0 → state=0, retired=0, mem_err=0, no strobes on the following cycle.
- ADD (0) then LW (5) with mem_ready high → state sequence 0,1,2,4,0,1,2,3,4; reg_w1 only in the WB cycles; wb_data=01 in LW WB; retired=2.
- BEQ with zero_flag=1, then BNE with zero_flag=1 → first: pc_we=1, pc_src=10 in EX; second: no pc_we in EX; both return to IF after 3 cycles.
- SW with mem_ready low 3 cycles then high → mem_write held 4 cycles, then IF; mem_err=0; total 7 cycles.
- LW with mem_ready never high, MEM_TIMEOUT=15 → 15 MEM cycles, then mem_err=1, IF, no reg_w1; error flag persists until reset.
- CALL then RET (mem_ready high) → CALL MEM: mem_write, reg_w2, pc_src=01; RET MEM: mem_read, pc_src=11. Opcode 40 → illegal_op=1 after ID, back to IF in 2 cycles.
